lut_neuron_prog: RTL

LUT_NEURON_PROG -- requirements
Module: lut_neuron_prog

---
 rtl/lut_neuron_pkg.sv | 18 +
 rtl/lut_neuron_ram.sv | 71 +++++++
 rtl/lut_neuron_prog.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared FSM state type, default neuron geometry and a width helper for the programmable LUT neuron.
package lut_neuron_pkg;

  localparam int LP_IN_BITS = 8;
  localparam int LP_BEAT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Keeps counters and indices at least one bit wide for degenerate geometries.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// BEATS x BEAT_W distributed RAM: word write port, registered single-bit lookup port and,
// with LUT_NEURON_PROG_READBACK_EN defined, a registered word readback port.
module lut_neuron_ram
  import lut_neuron_pkg::*;
#(
  parameter  int IN_BITS = LP_IN_BITS,
  parameter  int BEAT_W  = LP_BEAT_W,
  localparam int BEATS   = (2 ** IN_BITS) / BEAT_W,
  localparam int CNT_W   = clog2_min1(BEATS),
  localparam int OFS_W   = clog2_min1(BEAT_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [CNT_W-1:0]   i_waddr,
  input  logic [BEAT_W-1:0]  i_wdata,
  input  logic               i_rd_en,
  input  logic [IN_BITS-1:0] i_rd_addr,
  output logic               o_rd_bit
`ifdef LUT_NEURON_PROG_READBACK_EN
  ,
  input  logic               i_rb_en,
  input  logic [CNT_W-1:0]   i_rb_addr,
  output logic [BEAT_W-1:0]  o_rb_word
`endif
);

  logic [BEAT_W-1:0] r_mem [BEATS];
  logic [31:0]       w_rd_addr32;
  logic [CNT_W-1:0]  w_rd_word;
  logic [OFS_W-1:0]  w_rd_ofs;
  logic              r_rd_bit;

  // A table entry lives in word addr/BEAT_W at bit addr%BEAT_W.
  assign w_rd_addr32 = 32'(i_rd_addr);
  assign w_rd_word   = CNT_W'(w_rd_addr32 / 32'(BEAT_W));
  assign w_rd_ofs    = OFS_W'(w_rd_addr32 % 32'(BEAT_W));

  // NOTE: storage has no reset so it maps onto LUT RAM; only the read registers are reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // NOTE: non-blocking assignments give read-before-write on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_bit <= 1'b0;
    end else if (i_rd_en) begin
      r_rd_bit <= r_mem[w_rd_word][w_rd_ofs];
    end
  end

  assign o_rd_bit = r_rd_bit;

`ifdef LUT_NEURON_PROG_READBACK_EN
  logic [BEAT_W-1:0] r_rb_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rb_word <= '0;
    end else if (i_rb_en) begin
      r_rb_word <= r_mem[i_rb_addr];
    end
  end

  assign o_rb_word = r_rb_word;
`endif

endmodule

// File: rtl/lut_neuron_prog.sv
// Programmable LUT neuron: streams a 2**IN_BITS-entry truth table in BEAT_W-bit beats, then
// answers one lookup per cycle. Define LUT_NEURON_PROG_READBACK_EN to add the rb_* word readback port.
module lut_neuron_prog
  import lut_neuron_pkg::*;
#(
  parameter  int IN_BITS = LP_IN_BITS,
  parameter  int BEAT_W  = LP_BEAT_W,
  localparam int BEATS   = (2 ** IN_BITS) / BEAT_W,
  localparam int CNT_W   = clog2_min1(BEATS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [BEAT_W-1:0]  cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic               cfg_done,
  output logic               tbl_valid,
  input  logic [IN_BITS-1:0] M0,
  input  logic               in_valid,
  output logic               M1,
  output logic               out_valid
`ifdef LUT_NEURON_PROG_READBACK_EN
  ,
  input  logic [CNT_W-1:0]   rb_addr,
  input  logic               rb_en,
  output logic [BEAT_W-1:0]  rb_data
`endif
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_tbl_valid;
  logic             r_cfg_done;
  logic             r_out_valid;
  logic             w_cfg_ready;
  logic             w_accept;
  logic             w_last_beat;
  logic             w_lookup;

  assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_accept    = cfg_valid && w_cfg_ready;
  assign w_lookup    = in_valid && (r_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cfg_ready = 1'b0;
    case (r_state)
      IDLE, RUN: begin
        if (cfg_start) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        // A restart wins over a beat presented in the same cycle.
        w_cfg_ready = !cfg_start;
        if (!cfg_start && cfg_valid && w_last_beat) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_tbl_valid <= 1'b0;
      r_cfg_done  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_cfg_done  <= 1'b0;
      r_out_valid <= w_lookup;
      if (cfg_start) begin
        r_beat_cnt  <= '0;
        r_tbl_valid <= 1'b0;
      end else if (w_accept) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + CNT_W'(1);
        if (w_last_beat) begin
          r_tbl_valid <= 1'b1;
          r_cfg_done  <= 1'b1;
        end
      end
    end
  end

  lut_neuron_ram #(
    .IN_BITS (IN_BITS),
    .BEAT_W  (BEAT_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_accept && !rst),
    .i_waddr   (r_beat_cnt),
    .i_wdata   (cfg_data),
    .i_rd_en   (w_lookup),
    .i_rd_addr (M0),
    .o_rd_bit  (M1)
`ifdef LUT_NEURON_PROG_READBACK_EN
    ,
    .i_rb_en   (rb_en),
    .i_rb_addr (rb_addr),
    .o_rb_word (rb_data)
`endif
  );

  assign cfg_ready = w_cfg_ready;
  assign cfg_done  = r_cfg_done;
  assign tbl_valid = r_tbl_valid;
  assign out_valid = r_out_valid;

endmodule
